wb_write_queue: RTL and testbench

- Write-back queue that feeds the single write port of the 32x64 register file (regWrite/writeReg/writeData).
- Merges two result sources, the ALU path and the memory/load path, into an in-order FIFO.
- Drains one write per cycle into the register file.
- Drops writes to X31, the hardwired zero register.
- Optionally provides a pending-write forwarding lookup for the read stage.

---
 rtl/wb_write_queue.sv | 180 ++++++++++++++++++
 tb/tb_wb_write_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//
// Write-back queue in front of the single write port of the 32x64 register
// file. Results from the memory/load path and the ALU path are merged into one
// in-order FIFO and drained at one register-file write per cycle. Writes
// aimed at X31, the hardwired zero register, are accepted and then dropped.
//
// Optional feature (compile-time macro WB_FORWARD_EN):
//   When defined, lookupReg is compared against every pending write. Pending
//   writes are the queued entries plus the write currently being presented
//   to the register file. lookupData returns the youngest match.
//   When undefined, lookupHit and lookupData are tied to zero.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous, active-low, clears all control state
//   mem_valid  in   memory-path result valid
//   mem_ready  out  memory-path result accepted (when mem_valid=1)
//   mem_reg    in   memory-path destination register [ADDR_W]
//   mem_data   in   memory-path result [DATA_W]
//   alu_valid  in   ALU result valid
//   alu_ready  out  ALU result accepted (when alu_valid=1)
//   alu_reg    in   ALU destination register [ADDR_W]
//   alu_data   in   ALU result [DATA_W]
//   regWrite   out  register-file write enable (registered)
//   writeReg   out  register-file write index (registered)
//   writeData  out  register-file write data (registered)
//   count      out  occupied entries [$clog2(DEPTH)+1]
//   full       out  count == DEPTH
//   empty      out  count == 0
//   lookupReg  in   forwarding query index
//   lookupHit  out  a pending write to lookupReg exists
//   lookupData out  youngest pending data for lookupReg
// -----------------------------------------------------------------------------
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [ADDR_W-1:0]       mem_reg,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_reg,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    regWrite,
  output logic [ADDR_W-1:0]       writeReg,
  output logic [DATA_W-1:0]       writeData,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  input  logic [ADDR_W-1:0]       lookupReg,
  output logic                    lookupHit,
  output logic [DATA_W-1:0]       lookupData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  // Queue storage: data only, never reset (validity comes from the pointers).
  logic [ADDR_W-1:0] r_ent_reg  [DEPTH];
  logic [DATA_W-1:0] r_ent_data [DEPTH];

  // Control state.
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_regWrite;
  logic [ADDR_W-1:0] r_writeReg;
  logic [DATA_W-1:0] r_writeData;

  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  logic [1:0]        w_push_cnt;
  logic [PW-1:0]     w_alu_slot;
  logic [CW-1:0]     w_count_next;

  // Ready looks only at the registered count: a pop in this same cycle does
  // not free space until the next cycle, so overflow cannot happen. The ALU
  // path gives up one slot whenever the memory path is also offering.
  assign mem_ready = (r_count < CW'(DEPTH));
  assign alu_ready = mem_valid ? (r_count < CW'(DEPTH - 1))
                               : (r_count < CW'(DEPTH));

  // X31 transfers complete the handshake but never occupy an entry.
  assign w_mem_push = mem_valid & mem_ready & (mem_reg != ZERO_REG);
  assign w_alu_push = alu_valid & alu_ready & (alu_reg != ZERO_REG);
  assign w_pop      = (r_count != '0);

  assign w_push_cnt   = {1'b0, w_mem_push} + {1'b0, w_alu_push};
  // The mem entry is the older one; the ALU entry lands behind it.
  assign w_alu_slot   = r_tail + PW'(w_mem_push);
  assign w_count_next = r_count + CW'(w_push_cnt) - CW'(w_pop);

  // Control registers: pointers, occupancy and the register-file write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
    end else begin
      r_count <= w_count_next;
      r_tail  <= r_tail + PW'(w_push_cnt);
      if (w_pop) begin
        r_head      <= r_head + PW'(1);
        r_regWrite  <= 1'b1;
        r_writeReg  <= r_ent_reg[r_head];
        r_writeData <= r_ent_data[r_head];
      end else begin
        r_regWrite  <= 1'b0;
      end
    end
  end

  // Entry storage. A write during reset is harmless: the pointers are cleared
  // in the same edge, so the slot is never considered valid.
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_ent_reg[r_tail]  <= mem_reg;
      r_ent_data[r_tail] <= mem_data;
    end
    if (w_alu_push) begin
      r_ent_reg[w_alu_slot]  <= alu_reg;
      r_ent_data[w_alu_slot] <= alu_data;
    end
  end

  assign regWrite  = r_regWrite;
  assign writeReg  = r_writeReg;
  assign writeData = r_writeData;
  assign count     = r_count;
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);

`ifdef WB_FORWARD_EN
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd;

  // Scan from oldest to youngest so that later matches overwrite earlier
  // ones: the presented write first, then queue entries from head to tail.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    if (r_regWrite && (r_writeReg == lookupReg)) begin
      w_hit = 1'b1;
      w_fwd = r_writeData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_ent_reg[r_head + PW'(i)] == lookupReg)) begin
        w_hit = 1'b1;
        w_fwd = r_ent_data[r_head + PW'(i)];
      end
    end
    // The zero register never has a meaningful pending value.
    if (lookupReg == ZERO_REG) begin
      w_hit = 1'b0;
      w_fwd = '0;
    end
  end

  assign lookupHit  = w_hit;
  assign lookupData = w_fwd;
`else
  logic w_unused_lookup;
  assign w_unused_lookup = ^lookupReg;
  assign lookupHit  = 1'b0;
  assign lookupData = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_write_queue
//
// Directed bench for wb_write_queue. Every accepted non-X31 transfer is pushed
// onto a scoreboard queue (mem before alu); every regWrite pulse pops the
// oldest expectation and compares index and data. A small occupancy model
// supplies the expected ready, count, full and empty values.
// -----------------------------------------------------------------------------
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_valid, alu_valid;
  logic              mem_ready, alu_ready;
  logic [ADDR_W-1:0] mem_reg, alu_reg, lookupReg;
  logic [DATA_W-1:0] mem_data, alu_data;
  logic              regWrite, full, empty, lookupHit;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData, lookupData;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .count(count), .full(full), .empty(empty),
    .lookupReg(lookupReg), .lookupHit(lookupHit), .lookupData(lookupData)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  m_cnt  = 0;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md,
                       input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad);
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
  endtask

  // One clock: check readies before the edge, update the model, then check
  // the registered outputs on the following falling edge.
  task automatic tick();
    int  pushes;
    bit  exp_mr, exp_ar, exp_wr;
    wr_t e;
    #1;
    exp_wr = 1'b0;
    if (reset) begin
      exp_mr = (m_cnt < DEPTH);
      exp_ar = mem_valid ? (m_cnt < DEPTH - 1) : (m_cnt < DEPTH);
      chk("mem_ready", {63'd0, mem_ready}, {63'd0, exp_mr});
      chk("alu_ready", {63'd0, alu_ready}, {63'd0, exp_ar});
      exp_wr = (m_cnt > 0);
      pushes = 0;
      if (mem_valid && exp_mr && mem_reg != 5'd31) begin
        sb.push_back({mem_reg, mem_data}); pushes++;
      end
      if (alu_valid && exp_ar && alu_reg != 5'd31) begin
        sb.push_back({alu_reg, alu_data}); pushes++;
      end
      m_cnt = m_cnt + pushes - (exp_wr ? 1 : 0);
    end else begin
      sb.delete();
      m_cnt = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("count", {{(DATA_W-CW){1'b0}}, count}, DATA_W'(m_cnt));
    chk("empty", {63'd0, empty}, {63'd0, (m_cnt == 0)});
    chk("full",  {63'd0, full},  {63'd0, (m_cnt == DEPTH)});
    chk("regWrite", {63'd0, regWrite}, {63'd0, exp_wr});
    if (!reset) begin
      chk("rst_writeReg",  {59'd0, writeReg}, 64'd0);
      chk("rst_writeData", writeData, 64'd0);
    end else if (exp_wr) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("writeReg",  {59'd0, writeReg}, {59'd0, e.r});
        chk("writeData", writeData, e.d);
      end
    end
  endtask

  task automatic drain();
    int n;
    drive(0, 0, 0, 0, 0, 0);
    n = 0;
    while ((m_cnt != 0 || regWrite) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_done", DATA_W'(m_cnt), 64'd0);
    chk("sb_empty", DATA_W'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    lookupReg = '0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b1;

    // Single ALU write: visible one edge after it was queued.
    drive(0, 0, 0, 1, 5'd5, 64'hDEAD_BEEF);
    tick();
    chk("single_lat0", {63'd0, regWrite}, 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("single_wr", {63'd0, regWrite}, 64'd1);
    chk("single_reg", {59'd0, writeReg}, 64'd5);
    chk("single_data", writeData, 64'hDEAD_BEEF);
    tick();
    chk("single_done", {63'd0, regWrite}, 64'd0);
    chk("single_hold", writeData, 64'hDEAD_BEEF);

    // Dual push: mem entry is older than the alu entry.
    drive(1, 5'd3, 64'd1, 1, 5'd3, 64'd2);
    tick();
    chk("dual_peak", {{(DATA_W-CW){1'b0}}, count}, 64'd2);
    drain();

    // Forwarding lookup with two pending writes to X7.
    drive(1, 5'd7, 64'd10, 1, 5'd7, 64'd20);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    lookupReg = 5'd7;
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd_hit7", {63'd0, lookupHit}, 64'd1);
    chk("fwd_data7", lookupData, 64'd20);
`else
    chk("fwd_hit7", {63'd0, lookupHit}, 64'd0);
    chk("fwd_data7", lookupData, 64'd0);
`endif
    lookupReg = 5'd31;
    #1;
    chk("fwd_hit31", {63'd0, lookupHit}, 64'd0);
    chk("fwd_data31", lookupData, 64'd0);
    lookupReg = 5'd9;
    #1;
    chk("fwd_miss", {63'd0, lookupHit}, 64'd0);
    drain();

    // Back-pressure: climb to count 3, then alu is refused while mem offers.
    drive(1, 5'd1, 64'h11, 1, 5'd2, 64'h22);
    tick();
    drive(1, 5'd3, 64'h33, 1, 5'd4, 64'h44);
    tick();
    drive(1, 5'd5, 64'h55, 1, 5'd6, 64'h66);
    #1;
    chk("bp_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("bp_alu_ready", {63'd0, alu_ready}, 64'd0);
    tick();
    drive(0, 0, 0, 1, 5'd6, 64'h66);
    tick();
    chk("bp_max", {63'd0, (count <= CW'(DEPTH))}, 64'd1);
    drain();

    // X31 drops: empty queue and while entries are pending.
    drive(1, 5'd31, 64'hFF, 0, 0, 0);
    tick();
    chk("x31_count", {{(DATA_W-CW){1'b0}}, count}, 64'd0);
    drive(1, 5'd31, 64'hFF, 1, 5'd8, 64'h88);
    tick();
    drive(1, 5'd9, 64'h99, 1, 5'd31, 64'hAA);
    tick();
    drain();

    // Random mix including X31 targets.
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(28, 31)), {$urandom, $urandom},
            $urandom_range(0, 1), 5'($urandom_range(28, 31)), {$urandom, $urandom});
      tick();
    end
    drain();

    // Reset with three entries queued discards them all.
    drive(1, 5'd10, 64'hA0, 1, 5'd11, 64'hB0);
    tick();
    drive(1, 5'd12, 64'hC0, 1, 5'd13, 64'hD0);
    tick();
    chk("pre_rst_count", {{(DATA_W-CW){1'b0}}, count}, 64'd3);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_empty", {63'd0, empty}, 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
